// File: rtl/psum_pkg.sv
// Shared types and helpers for the partial-sum reduce/accumulate output stage.
// Holds the accumulator width rule, the output FSM states and a generic saturator.
package psum_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Widest signed value the saturator handles
    localparam int SAT_W = 128;

    // Accumulator width: lane width plus lane-reduction and pass growth
    function automatic int sum_width(
        input int acc_w,
        input int lanes,
        input int passes
    );
        return acc_w + $clog2(lanes) + $clog2(passes);
    endfunction

    // Clamp a signed value into the range of an ow-bit signed number
    function automatic logic signed [SAT_W-1:0] saturate(
        input logic signed [SAT_W-1:0] v,
        input int                      ow
    );
        logic signed [SAT_W-1:0] one;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        one = 1;
        hi  = (one <<< (ow - 1)) - one;
        lo  = -hi - one;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/coord_counter.sv
// Nested ch -> x -> y wrap counters that tag each output with its coordinate.
// Extents of zero behave as one; frame_done flags the final coordinate handshake.
module coord_counter #(
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int OUTPUT_NB_CHANNELS = 64
) (
    input  logic                                    clk,
    input  logic                                    arst_in,
    input  logic                                    advance,
    input  logic [$clog2(FEATURE_MAP_WIDTH+1)-1:0]  cfg_fm_width,
    input  logic [$clog2(FEATURE_MAP_HEIGHT+1)-1:0] cfg_fm_height,
    input  logic [$clog2(OUTPUT_NB_CHANNELS+1)-1:0] cfg_nb_ch,
    output logic [$clog2(FEATURE_MAP_WIDTH)-1:0]    output_x,
    output logic [$clog2(FEATURE_MAP_HEIGHT)-1:0]   output_y,
    output logic [$clog2(OUTPUT_NB_CHANNELS)-1:0]   output_ch,
    output logic                                    frame_done
);

    localparam int XCW = $clog2(FEATURE_MAP_WIDTH + 1);
    localparam int YCW = $clog2(FEATURE_MAP_HEIGHT + 1);
    localparam int CCW = $clog2(OUTPUT_NB_CHANNELS + 1);

    logic [XCW:0] x_next;
    logic [YCW:0] y_next;
    logic [CCW:0] ch_next;
    logic         x_last;
    logic         y_last;
    logic         ch_last;

    // Last-position detection; comparing index+1 against the extent also
    // treats a zero extent as one and copes with a shrunken extent
    always_comb begin
        x_next  = (XCW+1)'(output_x) + (XCW+1)'(1);
        y_next  = (YCW+1)'(output_y) + (YCW+1)'(1);
        ch_next = (CCW+1)'(output_ch) + (CCW+1)'(1);
        x_last  = x_next >= (XCW+1)'(cfg_fm_width);
        y_last  = y_next >= (YCW+1)'(cfg_fm_height);
        ch_last = ch_next >= (CCW+1)'(cfg_nb_ch);
    end

    assign frame_done = advance && ch_last && x_last && y_last;

    // Channel innermost, then x, then y; everything wraps at frame end
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            output_x  <= '0;
            output_y  <= '0;
            output_ch <= '0;
        end else if (advance) begin
            if (ch_last) begin
                output_ch <= '0;
                if (x_last) begin
                    output_x <= '0;
                    if (y_last) begin
                        output_y <= '0;
                    end else begin
                        output_y <= output_y + 1'b1;
                    end
                end else begin
                    output_x <= output_x + 1'b1;
                end
            end else begin
                output_ch <= output_ch + 1'b1;
            end
        end
    end

endmodule

// File: rtl/psum_reduce_accum.sv
// Reduces NUM_LANES partial sums, accumulates them over cfg_nb_passes inputs
// and presents the requantised result on valid/ready. Option: OUT_RELU_EN.
module psum_reduce_accum
    import psum_pkg::*;
#(
    parameter int NUM_LANES          = 4,
    parameter int ACC_WIDTH          = 32,
    parameter int IO_DATA_WIDTH      = 16,
    parameter int MAX_PASSES         = 64,
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int OUTPUT_NB_CHANNELS = 64
) (
    input  logic                                    clk,
    input  logic                                    arst_in,
    input  logic [$clog2(MAX_PASSES+1)-1:0]         cfg_nb_passes,
    input  logic [5:0]                              cfg_shift,
    input  logic [$clog2(FEATURE_MAP_WIDTH+1)-1:0]  cfg_fm_width,
    input  logic [$clog2(FEATURE_MAP_HEIGHT+1)-1:0] cfg_fm_height,
    input  logic [$clog2(OUTPUT_NB_CHANNELS+1)-1:0] cfg_nb_ch,
    input  logic signed [ACC_WIDTH-1:0]             lane_data [NUM_LANES],
    input  logic                                    in_valid,
    output logic                                    in_ready,
    output logic signed [IO_DATA_WIDTH-1:0]         out_data,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [$clog2(FEATURE_MAP_WIDTH)-1:0]    output_x,
    output logic [$clog2(FEATURE_MAP_HEIGHT)-1:0]   output_y,
    output logic [$clog2(OUTPUT_NB_CHANNELS)-1:0]   output_ch,
    output logic                                    frame_done
);

    localparam int PW = $clog2(MAX_PASSES + 1);
    localparam int SW = sum_width(ACC_WIDTH, NUM_LANES, MAX_PASSES);

    state_t                     state;
    logic signed [SW-1:0]       acc;
    logic [PW-1:0]              pass_cnt;
    logic [PW-1:0]              passes_q;
    logic [5:0]                 shift_q;

    logic signed [SW-1:0]       lane_ext [NUM_LANES];
    logic signed [SW-1:0]       lane_sum;
    logic [PW-1:0]              passes_raw;
    logic [PW-1:0]              passes_eff;
    logic [5:0]                 shift_eff;
    logic                       is_final;
    logic signed [SW-1:0]       acc_base;
    logic signed [SW-1:0]       acc_new;
    logic signed [SW-1:0]       shifted;
    logic signed [SW-1:0]       clamped;
    logic signed [IO_DATA_WIDTH-1:0] sat_data;
    logic                       accept;
    logic                       final_acc;
    logic                       out_hs;

    // Sign-extend every lane to the accumulator width
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign lane_ext[i] = {{(SW-ACC_WIDTH){lane_data[i][ACC_WIDTH-1]}},
                              lane_data[i]};
    end

    // Lane reduction; SW leaves headroom so no overflow handling is needed
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_sum = lane_sum + lane_ext[i];
        end
    end

    // Group config: live inputs on the first pass, latched copies afterwards
    always_comb begin
        passes_raw = (pass_cnt == '0) ? cfg_nb_passes : passes_q;
        passes_eff = (passes_raw == '0) ? PW'(1) : passes_raw;
        shift_eff  = (pass_cnt == '0) ? cfg_shift : shift_q;
        is_final   = pass_cnt == (passes_eff - PW'(1));
    end

    // Accumulate, shift (floor), optional ReLU, then saturate
    always_comb begin
        acc_base = (pass_cnt == '0) ? '0 : acc;
        acc_new  = acc_base + lane_sum;
        shifted  = acc_new >>> shift_eff;
`ifdef OUT_RELU_EN
        clamped  = shifted[SW-1] ? '0 : shifted;
`else
        clamped  = shifted;
`endif
        sat_data = IO_DATA_WIDTH'(saturate(
                       {{(SAT_W-SW){clamped[SW-1]}}, clamped},
                       IO_DATA_WIDTH));
    end

    // Only the final pass is blocked by an unconsumed result
    assign in_ready  = !(is_final && out_valid && !out_ready);
    assign accept    = in_valid && in_ready;
    assign final_acc = accept && is_final;
    assign out_hs    = out_valid && out_ready;

    // Accumulation, result capture and ACCUM/HOLD sequencing
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            state     <= ACCUM;
            acc       <= '0;
            pass_cnt  <= '0;
            passes_q  <= '0;
            shift_q   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                acc      <= acc_new;
                pass_cnt <= is_final ? '0 : pass_cnt + PW'(1);
                if (pass_cnt == '0) begin
                    passes_q <= cfg_nb_passes;
                    shift_q  <= cfg_shift;
                end
            end
            if (final_acc) begin
                out_data <= sat_data;
            end
            unique case (state)
                ACCUM: begin
                    if (final_acc) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_hs && !final_acc) begin
                        state     <= ACCUM;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ACCUM;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    coord_counter #(
        .FEATURE_MAP_WIDTH  (FEATURE_MAP_WIDTH),
        .FEATURE_MAP_HEIGHT (FEATURE_MAP_HEIGHT),
        .OUTPUT_NB_CHANNELS (OUTPUT_NB_CHANNELS)
    ) u_coord (
        .clk           (clk),
        .arst_in       (arst_in),
        .advance       (out_hs),
        .cfg_fm_width  (cfg_fm_width),
        .cfg_fm_height (cfg_fm_height),
        .cfg_nb_ch     (cfg_nb_ch),
        .output_x      (output_x),
        .output_y      (output_y),
        .output_ch     (output_ch),
        .frame_done    (frame_done)
    );

endmodule

// File: tb/tb_psum_reduce_accum.sv
// Directed bench for psum_reduce_accum with a result scoreboard and a
// reference model of accumulation, requantisation and coordinate tracking.
module tb_psum_reduce_accum;

    logic               clk = 1'b0;
    logic               arst_in = 1'b0;
    logic [6:0]         cfg_nb_passes = 7'd1;
    logic [5:0]         cfg_shift = 6'd0;
    logic [10:0]        cfg_fm_width = 11'd4;
    logic [10:0]        cfg_fm_height = 11'd4;
    logic [6:0]         cfg_nb_ch = 7'd4;
    logic signed [31:0] lane_data [4];
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [15:0]        out_data;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [9:0]         output_x;
    logic [9:0]         output_y;
    logic [5:0]         output_ch;
    logic               frame_done;

    int errors = 0;
    int checks = 0;

    logic [15:0] exp_q [$];
    int     m_pass = 0;
    int     m_passes = 1;
    int     m_shift = 0;
    longint m_acc = 0;
    int     mx = 0;
    int     my = 0;
    int     mch = 0;

    psum_reduce_accum dut (
        .clk           (clk),
        .arst_in       (arst_in),
        .cfg_nb_passes (cfg_nb_passes),
        .cfg_shift     (cfg_shift),
        .cfg_fm_width  (cfg_fm_width),
        .cfg_fm_height (cfg_fm_height),
        .cfg_nb_ch     (cfg_nb_ch),
        .lane_data     (lane_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .output_x      (output_x),
        .output_y      (output_y),
        .output_ch     (output_ch),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] requant(input longint a, input int sh);
        longint s;
        s = a >>> sh;
`ifdef OUT_RELU_EN
        if (s < 0) s = 0;
`endif
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return s[15:0];
    endfunction

    function automatic int ext(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic set_lanes(input int a, input int b, input int c,
                             input int d);
        lane_data[0] = a;
        lane_data[1] = b;
        lane_data[2] = c;
        lane_data[3] = d;
    endtask

    // One clock: check outputs against the model, then update the model
    task automatic tick();
        int     eff;
        logic   fin;
        logic   rdy;
        logic   hs;
        logic   fd;
        logic   acc;
        longint sum;
        #1;
        eff = ext(int'(m_pass == 0 ? cfg_nb_passes : 7'(m_passes)));
        fin = (m_pass == eff - 1);
        rdy = !(fin && exp_q.size() != 0 && !out_ready);
        hs  = exp_q.size() != 0 && out_ready;
        fd  = hs && (mch + 1 >= ext(int'(cfg_nb_ch)))
                 && (mx + 1 >= ext(int'(cfg_fm_width)))
                 && (my + 1 >= ext(int'(cfg_fm_height)));
        chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        chk("in_ready", 64'(in_ready), 64'(rdy));
        chk("frame_done", 64'(frame_done), 64'(fd));
        if (exp_q.size() != 0) begin
            chk("out_data", 64'(out_data), 64'(exp_q[0]));
            chk("output_ch", 64'(output_ch), 64'(mch));
            chk("output_x", 64'(output_x), 64'(mx));
            chk("output_y", 64'(output_y), 64'(my));
        end
        acc = in_valid && rdy;
        if (hs) begin
            void'(exp_q.pop_front());
            if (mch + 1 >= ext(int'(cfg_nb_ch))) begin
                mch = 0;
                if (mx + 1 >= ext(int'(cfg_fm_width))) begin
                    mx = 0;
                    my = (my + 1 >= ext(int'(cfg_fm_height))) ? 0 : my + 1;
                end else begin
                    mx++;
                end
            end else begin
                mch++;
            end
        end
        if (acc) begin
            sum = 0;
            for (int i = 0; i < 4; i++) sum += longint'(lane_data[i]);
            if (m_pass == 0) begin
                m_passes = int'(cfg_nb_passes);
                m_shift  = int'(cfg_shift);
                m_acc    = 0;
            end
            m_acc += sum;
            if (fin) begin
                exp_q.push_back(requant(m_acc, m_shift));
                m_pass = 0;
            end else begin
                m_pass++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        arst_in = 1'b1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_output_x", 64'(output_x), 64'(0));
        chk("rst_output_y", 64'(output_y), 64'(0));
        chk("rst_output_ch", 64'(output_ch), 64'(0));
        chk("rst_frame_done", 64'(frame_done), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        exp_q.delete();
        m_pass = 0;
        m_acc  = 0;
        mx = 0;
        my = 0;
        mch = 0;
        @(negedge clk);
        arst_in = 1'b0;
    endtask

    initial begin
        set_lanes(0, 0, 0, 0);
        #2;
        do_reset();

        // Single pass, plain sum
        cfg_nb_passes = 7'd1;
        cfg_shift = 6'd0;
        set_lanes(1, 2, 3, 4);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("ch_after_hs", 64'(output_ch), 64'(1));

        // Three passes with shift; config change mid-group is ignored
        cfg_nb_passes = 7'd3;
        cfg_shift = 6'd2;
        set_lanes(100, 100, 100, 100);
        in_valid = 1'b1;
        tick();
        cfg_nb_passes = 7'd1;
        cfg_shift = 6'd0;
        tick();
        tick();
        in_valid = 1'b0;
        tick();
        tick();

        // Saturation both ways and floor of a negative shift
        cfg_nb_passes = 7'd1;
        cfg_shift = 6'd0;
        in_valid = 1'b1;
        set_lanes(32767, 32767, 1, 0);
        tick();
        set_lanes(-20000, -20000, -20000, -20000);
        tick();
        cfg_shift = 6'd1;
        set_lanes(-1, -2, 0, 0);
        tick();
        in_valid = 1'b0;
        tick();

        // Back-pressure: final pass stalls, non-final pass still accepted
        cfg_shift = 6'd0;
        out_ready = 1'b0;
        in_valid = 1'b1;
        set_lanes(5, 6, 7, 8);
        tick();
        set_lanes(1, 1, 1, 1);
        tick();
        tick();
        cfg_nb_passes = 7'd2;
        set_lanes(10, 20, 30, 40);
        tick();
        tick();
        tick();
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();

        // Coordinate walk over a 2x2x2 frame, continuous traffic
        do_reset();
        cfg_nb_ch = 7'd2;
        cfg_fm_width = 11'd2;
        cfg_fm_height = 11'd2;
        cfg_nb_passes = 7'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_lanes(i, -3 * i, 7, i * i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        chk("coord_wrap_ch", 64'(output_ch), 64'(0));
        chk("coord_wrap_x", 64'(output_x), 64'(1));

        // Reset mid-group discards the partial accumulation
        cfg_nb_passes = 7'd3;
        cfg_shift = 6'd1;
        set_lanes(5, 5, 5, 5);
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        do_reset();
        in_valid = 1'b1;
        tick();
        tick();
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("drained", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
